// File: rtl/ir_peak_detector_if.sv
// rtl/ir_peak_detector_if.sv - sample-in / beat-report bundle for ir_peak_detector
//
// Purpose: carries the filtered IR sample stream into the peak detector and
// the beat report back out to the SpO2 / heart-rate back end.
//   master : sample source (drives Sample_En, Filtered_In; observes results)
//   slave  : peak detector (consumes samples; drives Beat .. Signal_Lost)
// Signals:
//   Sample_En    - Filtered_In carries a new sample this cycle
//   Filtered_In  - unsigned filtered IR sample, DW bits
//   Beat         - one-cycle strobe per accepted peak
//   Beat_Period  - samples between the last two accepted peaks, CW bits
//   Peak_Value   - level of last accepted peak
//   Valley_Value - level of last confirmed valley
//   Amplitude    - Peak_Value - Valley_Value, floored at 0
//   Signal_Lost  - no accepted beat for MAX_PERIOD samples
interface ir_peak_detector_if #(
    parameter int DW = 20,
    parameter int CW = 11
);
    logic          Sample_En;
    logic [DW-1:0] Filtered_In;
    logic          Beat;
    logic [CW-1:0] Beat_Period;
    logic [DW-1:0] Peak_Value;
    logic [DW-1:0] Valley_Value;
    logic [DW-1:0] Amplitude;
    logic          Signal_Lost;

    modport master (
        output Sample_En, Filtered_In,
        input  Beat, Beat_Period, Peak_Value, Valley_Value, Amplitude, Signal_Lost
    );

    modport slave (
        input  Sample_En, Filtered_In,
        output Beat, Beat_Period, Peak_Value, Valley_Value, Amplitude, Signal_Lost
    );
endinterface

// File: rtl/ir_peak_detector.sv
// rtl/ir_peak_detector.sv - hysteresis peak/valley beat detector for the filtered IR waveform
//
// Purpose: tracks systolic peaks and diastolic valleys of the FIR-filtered IR
// signal with a hysteresis state machine, and reports each accepted beat with
// its period, peak/valley levels and AC amplitude.
// Ports:
//   CLK_Filter - filter clock (only clock)
//   rst        - synchronous active-high reset
//   pk         - ir_peak_detector_if.slave: Sample_En/Filtered_In in,
//                Beat/Beat_Period/Peak_Value/Valley_Value/Amplitude/Signal_Lost out
// Build option:
//   PEAK_DET_AVG_EN - when defined, Beat_Period is the truncated mean of the
//                     last 4 accepted periods instead of the latest period.
module ir_peak_detector #(
    parameter int DW         = 20,
    parameter int HYST       = 2000,
    parameter int WARMUP     = 25,
    parameter int MIN_PERIOD = 100,
    parameter int MAX_PERIOD = 1000,
    parameter int CW         = 11
) (
    input  logic                  CLK_Filter,
    input  logic                  rst,
    ir_peak_detector_if.slave     pk
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SEEK_MAX = 2'd1,
        SEEK_MIN = 2'd2
    } state_t;

    localparam logic [DW-1:0] HYST_C   = DW'(HYST);
    localparam logic [CW-1:0] WARMUP_C = CW'(WARMUP);
    localparam logic [CW-1:0] MIN_C    = CW'(MIN_PERIOD);
    localparam logic [CW-1:0] MAX_C    = CW'(MAX_PERIOD);

    state_t        state_q, state_d;
    logic [DW-1:0] cur_max_q, cur_max_d;
    logic [DW-1:0] cur_min_q, cur_min_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          armed_q, armed_d;
    logic          beat_q, beat_d;
    logic [CW-1:0] period_q, period_d;
    logic [DW-1:0] peak_q, peak_d;
    logic [DW-1:0] valley_q, valley_d;
    logic [DW-1:0] amp_q, amp_d;
    logic          lost_q, lost_d;

`ifdef PEAK_DET_AVG_EN
    logic [CW-1:0] hist_q [4];
    logic [CW-1:0] hist_d [4];
    logic          fresh_q, fresh_d;
    logic [CW+1:0] hist_sum;
`endif

    logic [DW-1:0] smp;
    logic [DW-1:0] hi;
    logic [DW-1:0] lo;
    logic [CW-1:0] cnt_inc;
    logic          peak_conf;
    logic          valley_conf;

    assign smp = pk.Filtered_In;

    // Running extremes including this sample; they keep the hysteresis
    // differences non-negative so unsigned subtraction never wraps.
    assign hi      = (smp > cur_max_q) ? smp : cur_max_q;
    assign lo      = (smp < cur_min_q) ? smp : cur_min_q;
    assign cnt_inc = (cnt_q >= MAX_C) ? MAX_C : cnt_q + CW'(1);

    assign peak_conf   = (state_q == SEEK_MAX) && ((hi - smp) > HYST_C);
    assign valley_conf = (state_q == SEEK_MIN) && ((smp - lo) > HYST_C);

    always_comb begin
        state_d   = state_q;
        cur_max_d = cur_max_q;
        cur_min_d = cur_min_q;
        cnt_d     = cnt_q;
        armed_d   = armed_q;
        beat_d    = 1'b0;
        period_d  = period_q;
        peak_d    = peak_q;
        valley_d  = valley_q;
        amp_d     = amp_q;
        lost_d    = lost_q;
`ifdef PEAK_DET_AVG_EN
        hist_d    = hist_q;
        fresh_d   = fresh_q;
        hist_sum  = '0;
`endif
        if (pk.Sample_En) begin
            case (state_q)
                IDLE: begin
                    // cnt doubles as the warm-up counter while idle.
                    if (cnt_q == WARMUP_C) begin
                        cur_max_d = smp;
                        cnt_d     = '0;
                        state_d   = SEEK_MAX;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                SEEK_MAX: begin
                    cur_max_d = hi;
                    cnt_d     = cnt_inc;
                    if (peak_conf) begin
                        cur_min_d = smp;
                        state_d   = SEEK_MIN;
                        if (!armed_q) begin
                            // First peak after reset or loss only sets the
                            // reference point for period measurement.
                            armed_d = 1'b1;
                            cnt_d   = '0;
`ifdef PEAK_DET_AVG_EN
                            fresh_d = 1'b1;
`endif
                        end else if (cnt_inc >= MIN_C) begin
                            beat_d = 1'b1;
                            peak_d = hi;
                            amp_d  = (hi >= valley_q) ? (hi - valley_q) : '0;
                            lost_d = 1'b0;
                            cnt_d  = '0;
`ifdef PEAK_DET_AVG_EN
                            if (fresh_q) begin
                                for (int i = 0; i < 4; i++) hist_d[i] = cnt_inc;
                            end else begin
                                for (int i = 3; i > 0; i--) hist_d[i] = hist_q[i-1];
                                hist_d[0] = cnt_inc;
                            end
                            fresh_d = 1'b0;
                            for (int i = 0; i < 4; i++) hist_sum = hist_sum + (CW+2)'(hist_d[i]);
                            period_d = hist_sum[CW+1:2];
`else
                            period_d = cnt_inc;
`endif
                        end
                        // Peaks closer than MIN_PERIOD fall through: no beat,
                        // cnt keeps running from the previous accepted peak.
                    end
                end
                SEEK_MIN: begin
                    cur_min_d = lo;
                    cnt_d     = cnt_inc;
                    if (valley_conf) begin
                        valley_d  = lo;
                        cur_max_d = smp;
                        state_d   = SEEK_MAX;
                    end
                end
                default: state_d = IDLE;
            endcase

            // Arm/accept clear cnt_d, so an accepted peak on the saturating
            // sample suppresses the loss declaration.
            if ((state_q != IDLE) && (cnt_d == MAX_C)) begin
                lost_d  = 1'b1;
                armed_d = 1'b0;
            end
        end
    end

    always_ff @(posedge CLK_Filter) begin
        if (rst) begin
            state_q   <= IDLE;
            cur_max_q <= '0;
            cur_min_q <= '0;
            cnt_q     <= '0;
            armed_q   <= 1'b0;
            beat_q    <= 1'b0;
            period_q  <= '0;
            peak_q    <= '0;
            valley_q  <= '0;
            amp_q     <= '0;
            lost_q    <= 1'b0;
`ifdef PEAK_DET_AVG_EN
            for (int i = 0; i < 4; i++) hist_q[i] <= '0;
            fresh_q   <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cur_max_q <= cur_max_d;
            cur_min_q <= cur_min_d;
            cnt_q     <= cnt_d;
            armed_q   <= armed_d;
            beat_q    <= beat_d;
            period_q  <= period_d;
            peak_q    <= peak_d;
            valley_q  <= valley_d;
            amp_q     <= amp_d;
            lost_q    <= lost_d;
`ifdef PEAK_DET_AVG_EN
            for (int i = 0; i < 4; i++) hist_q[i] <= hist_d[i];
            fresh_q   <= fresh_d;
`endif
        end
    end

    assign pk.Beat         = beat_q;
    assign pk.Beat_Period  = period_q;
    assign pk.Peak_Value   = peak_q;
    assign pk.Valley_Value = valley_q;
    assign pk.Amplitude    = amp_q;
    assign pk.Signal_Lost  = lost_q;

endmodule

// File: tb/tb_ir_peak_detector.sv
// tb/tb_ir_peak_detector.sv - randomized self-checking bench for ir_peak_detector
module tb_ir_peak_detector;

    localparam int DW     = 20;
    localparam int CW     = 11;
    localparam int HYST   = 2000;
    localparam int WARMUP = 25;
    localparam int MINP   = 100;
    localparam int MAXP   = 1000;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    ir_peak_detector_if #(.DW(DW), .CW(CW)) pk ();

    ir_peak_detector #(
        .DW(DW), .HYST(HYST), .WARMUP(WARMUP),
        .MIN_PERIOD(MINP), .MAX_PERIOD(MAXP), .CW(CW)
    ) dut (
        .CLK_Filter(clk),
        .rst       (rst),
        .pk        (pk)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int m_n;
    bit m_on, m_up, m_armed, m_fresh;
    int m_hi, m_lo, m_since;
    int m_last4[$];
    int e_beat, e_period, e_peak, e_valley, e_amp, e_lost;

    function automatic void m_reset();
        m_n = 0; m_on = 0; m_up = 0; m_armed = 0; m_fresh = 0;
        m_hi = 0; m_lo = 0; m_since = 0;
        m_last4.delete();
        e_beat = 0; e_period = 0; e_peak = 0; e_valley = 0; e_amp = 0; e_lost = 0;
    endfunction

    function automatic void m_step(input int s);
        int sum;
        e_beat = 0;
        m_n++;
        if (!m_on) begin
            if (m_n > WARMUP) begin
                m_on = 1; m_up = 1; m_hi = s; m_since = 0;
            end
            return;
        end
        if (m_since < MAXP) m_since++;
        if (m_up) begin
            if (s > m_hi) m_hi = s;
            if (m_hi - s > HYST) begin
                if (!m_armed) begin
                    m_armed = 1; m_since = 0; m_fresh = 1;
                end else if (m_since >= MINP) begin
                    e_beat = 1;
                    e_peak = m_hi;
                    e_amp  = (m_hi > e_valley) ? m_hi - e_valley : 0;
                    e_lost = 0;
                    if (m_fresh) m_last4 = {m_since, m_since, m_since, m_since};
                    else begin
                        m_last4.push_back(m_since);
                        void'(m_last4.pop_front());
                    end
                    m_fresh = 0;
`ifdef PEAK_DET_AVG_EN
                    sum = 0;
                    foreach (m_last4[k]) sum += m_last4[k];
                    e_period = sum / 4;
`else
                    sum = m_since;
                    e_period = sum;
`endif
                    m_since = 0;
                end
                m_lo = s; m_up = 0;
            end
        end else begin
            if (s < m_lo) m_lo = s;
            if (s - m_lo > HYST) begin
                e_valley = m_lo; m_hi = s; m_up = 1;
            end
        end
        if (m_since == MAXP) begin
            e_lost = 1; m_armed = 0;
        end
    endfunction

    // ---------------- stimulus helpers ----------------
    typedef struct {
        int idx; int period; int peak; int valley; int amp;
    } beat_t;

    int    wave[$];
    beat_t beats[$];
    int    first_lost;

    task automatic cmp_all(input string where);
        chk({where, "_beat"},   32'(pk.Beat),         e_beat);
        chk({where, "_period"}, 32'(pk.Beat_Period),  e_period);
        chk({where, "_peak"},   32'(pk.Peak_Value),   e_peak);
        chk({where, "_valley"}, 32'(pk.Valley_Value), e_valley);
        chk({where, "_amp"},    32'(pk.Amplitude),    e_amp);
        chk({where, "_lost"},   32'(pk.Signal_Lost),  e_lost);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        pk.Sample_En = 1'b0;
        pk.Filtered_In = DW'($urandom);
        repeat (2) @(posedge clk);
        #1;
        m_reset();
        beats.delete();
        first_lost = -1;
        cmp_all("rst");
        rst = 1'b0;
    endtask

    task automatic idle(input int n);
        e_beat = 0;
        pk.Sample_En = 1'b0;
        for (int k = 0; k < n; k++) begin
            pk.Filtered_In = DW'($urandom);
            @(posedge clk);
            #1;
            cmp_all("idle");
        end
    endtask

    task automatic run_wave(input int gap_pct, input int long_gap_at);
        foreach (wave[i]) begin
            if (i == long_gap_at) idle(50);
            if (gap_pct > 0 && int'($urandom_range(99)) < gap_pct) idle(int'($urandom_range(1, 3)));
            pk.Sample_En = 1'b1;
            pk.Filtered_In = DW'(wave[i]);
            @(posedge clk);
            #1;
            m_step(wave[i]);
            cmp_all("smp");
            pk.Sample_En = 1'b0;
            if (pk.Beat)
                beats.push_back('{m_n, int'(pk.Beat_Period), int'(pk.Peak_Value),
                                  int'(pk.Valley_Value), int'(pk.Amplitude)});
            if (pk.Signal_Lost && first_lost < 0) first_lost = m_n;
        end
        wave.delete();
    endtask

    function automatic void add_line(input int start, input int step, input int n);
        for (int k = 0; k < n; k++) wave.push_back(start + step * k);
    endfunction

    function automatic void add_tri(input int n);
        for (int c = 0; c < n; c++) begin
            add_line(200000, 400, 250);
            add_line(300000, -400, 250);
        end
    endfunction

    initial begin
        int per_exp[4];
        int nb;
        int cur;
        rst = 1'b1;
        pk.Sample_En = 1'b0;
        pk.Filtered_In = '0;

        // Reset and warm-up: explicit zero outputs, then a ramp with no beat.
        do_reset();
        chk("reset_beat", 32'(pk.Beat), 0);
        chk("reset_period", 32'(pk.Beat_Period), 0);
        chk("reset_lost", 32'(pk.Signal_Lost), 0);
        add_line(1000, 1000, WARMUP);
        run_wave(0, -1);
        chk("warmup_no_beat", beats.size(), 0);
        chk("warmup_amp", 32'(pk.Amplitude), 0);

        // Triangle 200k..300k, period 500, random gaps and a 50-cycle mid-rise gap.
        add_tri(6);
        run_wave(10, 3 * 500 + 120);
        chk("tri_beat_count", beats.size(), 5);
        foreach (beats[k]) begin
            chk("tri_period", beats[k].period, 500);
            chk("tri_peak",   beats[k].peak,   300000);
            chk("tri_valley", beats[k].valley, 200000);
            chk("tri_amp",    beats[k].amp,    100000);
        end

        // Sub-hysteresis ripple, loss onset, then recovery by a real wave.
        do_reset();
        for (int k = 0; k < 1100; k++) wave.push_back(250000 + int'($urandom_range(1800)) - 900);
        run_wave(10, -1);
        chk("ripple_no_beat", beats.size(), 0);
        chk("ripple_lost_onset", first_lost, WARMUP + 1 + MAXP);
        chk("ripple_lost_level", 32'(pk.Signal_Lost), 1);
        add_line(250000, 400, 125);
        add_line(300000, -400, 250);
        add_tri(3);
        run_wave(10, -1);
        chk("recover_beats", beats.size(), 3);
        if (beats.size() > 0) chk("recover_first_period", beats[0].period, 500);
        chk("recover_lost_clear", 32'(pk.Signal_Lost), 0);

        // Double peak: a 50k bump 60 samples after each main apex is rejected.
        do_reset();
        add_line(200000, 0, 30);
        for (int c = 0; c < 6; c++)
            for (int p = 0; p < 500; p++) begin
                cur = (p < 250) ? 200000 + 400 * p : 300000 - 400 * (p - 250);
                if (p >= 290 && p <= 330) cur += 50000 - 2500 * ((p > 310) ? p - 310 : 310 - p);
                wave.push_back(cur);
            end
        run_wave(10, -1);
        chk("dbl_beat_count", beats.size(), 5);
        foreach (beats[k]) begin
            chk("dbl_period", beats[k].period, 500);
            chk("dbl_peak",   beats[k].peak,   300000);
        end

        // Period averaging: spacings 400, 400, 400, 800.
        do_reset();
        add_line(200000, 0, 30);
        foreach (per_exp[k]) per_exp[k] = 0;
        begin
            int lens[5];
            lens = '{400, 400, 400, 800, 300};
            foreach (lens[k]) begin
                add_line(200000, 1000, 100);
                add_line(300000, -1000, 100);
                add_line(200000, 0, lens[k] - 200);
            end
        end
        run_wave(10, -1);
`ifdef PEAK_DET_AVG_EN
        per_exp = '{400, 400, 400, 500};
`else
        per_exp = '{400, 400, 400, 800};
`endif
        chk("avg_beat_count", beats.size(), 4);
        nb = (beats.size() < 4) ? beats.size() : 4;
        for (int k = 0; k < nb; k++) chk("avg_period", beats[k].period, per_exp[k]);

        // Random piecewise-linear waveform with noise and random gaps.
        do_reset();
        cur = 200000;
        for (int seg = 0; seg < 40; seg++) begin
            int tgt, len;
            tgt = 100000 + int'($urandom_range(300000));
            len = 30 + int'($urandom_range(270));
            for (int k = 1; k <= len; k++)
                wave.push_back(cur + ((tgt - cur) * k) / len + int'($urandom_range(1000)) - 500);
            cur = tgt;
        end
        run_wave(20, -1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
